// File: rtl/mopa_unit.sv
// Outer-product accumulate engine: M[i][j] +/- rs1[i]*rs2[j] over 4x4 signed 8-bit lanes,
// returned as one 4-row write. Define MOPA_SAT_EN for saturating lanes plus a sat_flag output.
module mopa_unit #(
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic [3:0][31:0] M_in,
  output logic             busy,
  output logic             done,
  output logic [3:0][31:0] w_matrix_data_mopa,
  output logic             w_matrix_en_mopa
`ifdef MOPA_SAT_EN
  ,
  output logic             sat_flag
`endif
);

  // Row counter step and final value; with 4 rows per cycle both truncate to 0,
  // so the single CALC cycle is also the last one.
  localparam logic [1:0] ROW_STEP = 2'(ROWS_PER_CYCLE);
  localparam logic [1:0] LAST_ROW = 2'(4 - ROWS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

  state_t           state, state_d;
  logic [31:0]      a_q, b_q;
  logic             sub_q;
  logic [3:0][31:0] m_q;
  logic [3:0][31:0] res_q, res_d;
  logic [1:0]       row_q, row_idx;

`ifdef MOPA_SAT_EN
  logic sat_acc, sat_d;
`endif

  // Full-precision lane: sign-extended M +/- 16-bit signed product, at 17 bits.
  function automatic logic [16:0] lane_sum(input logic [7:0] m, input logic [7:0] a,
                                           input logic [7:0] b, input logic sub);
    logic signed [15:0] prod;
    logic [16:0]        m_ext, p_ext;
    prod  = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
    m_ext = {{9{m[7]}}, m};
    p_ext = {prod[15], prod};
    return sub ? (m_ext - p_ext) : (m_ext + p_ext);
  endfunction

  function automatic logic [7:0] lane_result(input logic [16:0] sum);
`ifdef MOPA_SAT_EN
    if ($signed(sum) > 17'sd127)  return 8'h7f;
    if ($signed(sum) < -17'sd128) return 8'h80;
`endif
    return sum[7:0];
  endfunction

`ifdef MOPA_SAT_EN
  function automatic logic lane_clamped(input logic [16:0] sum);
    return ($signed(sum) > 17'sd127) || ($signed(sum) < -17'sd128);
  endfunction
`endif

  // Rows row_q .. row_q+ROWS_PER_CYCLE-1 are recomputed from the snapshot each CALC cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    res_d   = res_q;
    row_idx = row_q;
`ifdef MOPA_SAT_EN
    sat_d   = 1'b0;
`endif
    for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
      row_idx = row_q + 2'(k);
      for (int j = 0; j < 4; j++) begin
        res_d[row_idx][8*j +: 8] = lane_result(lane_sum(m_q[row_idx][8*j +: 8],
                                                        a_q[8*row_idx +: 8],
                                                        b_q[8*j +: 8], sub_q));
`ifdef MOPA_SAT_EN
        sat_d = sat_d | lane_clamped(lane_sum(m_q[row_idx][8*j +: 8],
                                              a_q[8*row_idx +: 8],
                                              b_q[8*j +: 8], sub_q));
`endif
      end
    end
  end

  always_comb begin
    state_d          = state;
    busy             = 1'b0;
    done             = 1'b0;
    w_matrix_en_mopa = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (row_q == LAST_ROW) state_d = WRITE;
      end
      WRITE: begin
        busy             = 1'b1;
        done             = 1'b1;
        w_matrix_en_mopa = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-low; the snapshot and result registers are
    // cleared too, so a mid-operation reset leaves no stale operand or result behind.
    if (!rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      m_q   <= '0;
      res_q <= '0;
      row_q <= '0;
`ifdef MOPA_SAT_EN
      sat_acc  <= 1'b0;
      sat_flag <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state <= state_d;
      if (state == IDLE && start) begin
        a_q   <= rs1_data;
        b_q   <= rs2_data;
        sub_q <= op_sub;
        m_q   <= M_in;
        row_q <= '0;
`ifdef MOPA_SAT_EN
        sat_acc  <= 1'b0;
        sat_flag <= 1'b0;
`endif
      end
      if (state == CALC) begin
        res_q <= res_d;
        row_q <= row_q + ROW_STEP;
`ifdef MOPA_SAT_EN
        sat_acc <= sat_acc | sat_d;
        if (row_q == LAST_ROW) sat_flag <= sat_acc | sat_d;
`endif
      end
    end
  end

  assign w_matrix_data_mopa = res_q;

endmodule
